store_merge_unit: RTL

Store-side data formatter for the single-cycle CPU's data memory path, the narrowing counterpart of the load-side sign extension. It accepts 32-bit store requests of byte, halfword or word size, truncates the register data to the requested width and places it in the correct byte lane. Because the data memory accepts only full-word writes, it performs read-modify-write for sub-word stores. A small request FIFO decouples the core from memory latency.

---
 rtl/store_pkg.sv | 18 +
 rtl/store_fifo.sv | 30 +++
 rtl/store_merge_unit.sv | 67 ++++++
 3 files changed

// File: rtl/store_pkg.sv
// store_pkg: size encodings, FSM states, FIFO entry layout and lane-merge helper
package store_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  typedef struct packed {
    logic [29:0] waddr;
    logic [1:0]  lane;
    logic [1:0]  size;
    logic [31:0] data;
  } entry_t;
  function automatic logic [31:0] merge(input logic [31:0] old, input entry_t e);
    logic [31:0] mask;
    mask = (e.size == SZ_BYTE ? 32'h0000_00ff : e.size == SZ_HALF ? 32'h0000_ffff : 32'hffff_ffff) << {e.lane, 3'b000};
    return (old & ~mask) | ((e.data << {e.lane, 3'b000}) & mask);
  endfunction
endpackage

// File: rtl/store_fifo.sv
// store_fifo: synchronous request FIFO with full/empty flags
module store_fifo import store_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output entry_t dout,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk_i)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/store_merge_unit.sv
// store_merge_unit: narrows store data into byte lanes, read-modify-write for sub-word stores
module store_merge_unit import store_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  input  logic [1:0]  req_size_i,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        misalign_o,
  output logic        busy_o
);
  state_t state, next;
  entry_t head, din;
  logic full, empty, accept, legal, push, pop;
  logic [31:0] wbuf;
  assign accept = req_valid_i && req_ready_o;
  assign legal = req_size_i == SZ_WORD ? req_addr_i[1:0] == 2'b00 :
                 req_size_i == SZ_HALF ? !req_addr_i[0] : req_size_i == SZ_BYTE;
  assign push = accept && legal;
  assign pop = state == WRITE && mem_ack_i;
  assign din = '{waddr: req_addr_i[31:2], lane: req_addr_i[1:0], size: req_size_i,
                 data: req_size_i == SZ_BYTE ? {24'h0, req_data_i[7:0]} :
                       req_size_i == SZ_HALF ? {16'h0, req_data_i[15:0]} : req_data_i};
  assign req_ready_o = !full;
  assign busy_o = !empty || state != IDLE;
  assign mem_rd_o = state == READ;
  assign mem_wr_o = state == WRITE;
  // strobes, address and data derive from state so an async reset drops them at once
  assign mem_addr_o = state == IDLE ? '0 : {head.waddr, 2'b00};
  assign mem_wdata_o = mem_wr_o ? wbuf : '0;
  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push(push),
    .pop(pop),
    .din(din),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    next = state == IDLE ? (empty ? IDLE : head.size == SZ_WORD ? WRITE : READ) :
           state == READ ? (mem_ack_i ? WRITE : READ) : (mem_ack_i ? IDLE : WRITE);
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      wbuf <= '0;
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= accept && !legal;
      if (state == IDLE && !empty && head.size == SZ_WORD) wbuf <= head.data;
      else if (state == READ && mem_ack_i) wbuf <= merge(mem_rdata_i, head);
    end
endmodule
